// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared definitions for the PS/2 keyboard subsystem: transmit
//             FSM state encoding, common host command bytes, ACK line level
//             and a small constant helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    // Host-to-device transmit FSM states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INHIBIT  = 4'd1,
        ST_START    = 4'd2,
        ST_DATA     = 4'd3,
        ST_PARITY   = 4'd4,
        ST_STOP     = 4'd5,
        ST_WAIT_ACK = 4'd6,
        ST_SENT     = 4'd7,
        ST_ERROR    = 4'd8
    } ps2_tx_state_e;

    // Frequently used keyboard commands
    localparam logic [7:0] PS2_CMD_SET_LEDS     = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE       = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET        = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_SCANCODE = 8'hF0;

    // Level the device drives on PS2_DAT to acknowledge a received byte
    localparam logic PS2_ACK_LEVEL = 1'b0;

    // Larger of two integers, used to size shared counters at elaboration
    function automatic int ps2_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_timeout_counter.sv
// ============================================================================
//  Module   : ps2_timeout_counter
//  Brief    : Clearable, enabled up-counter with a run-time terminal count.
//             Saturates at the terminal count (never wraps). o_expired is
//             high during the cycle in which the i_limit-th enabled cycle
//             since the last clear is being counted.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_timeout_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_tc;

    // Terminal count reached once limit-1 cycles have already been counted
    assign w_at_tc   = (r_count >= (i_limit - WIDTH'(1)));
    assign o_expired = i_enable && w_at_tc;

    // Count enabled cycles; clear on load, hold once the terminal count is hit
    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_count <= '0;
        end else if (i_enable && !w_at_tc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_command_out.sv
// ============================================================================
//  Module   : ps2_command_out
//  Brief    : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//             start bit, clocks out 8 data bits LSB first, odd parity and a
//             stop bit on device falling edges, then waits for the device
//             ACK. Open-drain lines are expressed as drive-low enables.
//  Config   : define PS2_CMD_OUT_ACK_CHECK_EN to require PS2_DAT low at the
//             ACK edge (high reports an error); otherwise any ACK edge
//             completes the transfer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int DATA_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int c_TMR_MAX = ps2_max(ps2_max(INHIBIT_CYCLES, START_TIMEOUT), DATA_TIMEOUT);
    localparam int c_TW      = $clog2(c_TMR_MAX + 1);

    ps2_tx_state_e   r_state, w_state_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_parity, w_parity_nxt;
    logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic            r_data_low, w_data_low_nxt;

    logic            w_tmr_load;
    logic            w_tmr_en;
    logic [c_TW-1:0] w_tmr_limit;
    logic            w_tmr_expired;

    // Rising-edge pulses are wired in only because the edge detectors are
    // shared with the receive path; this transmitter times on falling edges.
    logic            w_unused_inputs;
    assign w_unused_inputs = ps2_clk_posedge ^ ps2_data;

    // One timer serves the inhibit period and both timeouts
    ps2_timeout_counter #(
        .WIDTH (c_TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmr_load),
        .i_enable  (w_tmr_en),
        .i_limit   (w_tmr_limit),
        .o_expired (w_tmr_expired)
    );

    // State, shift register, parity, bit count and data drive registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_data_low <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_data_low <= w_data_low_nxt;
        end
    end

    // Next-state, bit sequencing and timer control
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_data_low_nxt = r_data_low;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_limit    = c_TW'(DATA_TIMEOUT);

        case (r_state)
            ST_IDLE: begin
                // Keep the timer cleared so INHIBIT starts from zero
                w_tmr_load     = 1'b1;
                w_data_low_nxt = 1'b0;
                if (send_command) begin
                    w_shift_nxt   = the_command;
                    w_parity_nxt  = ~^the_command;
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                w_tmr_en    = 1'b1;
                w_tmr_limit = c_TW'(INHIBIT_CYCLES);
                if (w_tmr_expired) begin
                    w_tmr_load     = 1'b1;
                    w_data_low_nxt = 1'b1;      // start bit = 0
                    w_state_nxt    = ST_START;
                end
            end

            ST_START: begin
                w_tmr_en    = 1'b1;
                w_tmr_limit = c_TW'(START_TIMEOUT);
                if (w_tmr_expired) begin
                    w_data_low_nxt = 1'b0;
                    w_state_nxt    = ST_ERROR;
                end else if (ps2_clk_negedge) begin
                    // First device edge: present bit 0 and start the data timer
                    w_tmr_load     = 1'b1;
                    w_data_low_nxt = ~r_shift[0];
                    w_shift_nxt    = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt  = 4'd1;
                    w_state_nxt    = ST_DATA;
                end
            end

            ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_ACK: begin
                w_tmr_en = 1'b1;
                // Timeout takes priority over a coincident falling edge
                if (w_tmr_expired) begin
                    w_data_low_nxt = 1'b0;
                    w_state_nxt    = ST_ERROR;
                end else if (ps2_clk_negedge) begin
                    case (r_state)
                        ST_DATA: begin
                            w_data_low_nxt = ~r_shift[0];
                            w_shift_nxt    = {1'b0, r_shift[7:1]};
                            w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                w_state_nxt = ST_PARITY;
                            end
                        end
                        ST_PARITY: begin
                            w_data_low_nxt = ~r_parity;
                            w_state_nxt    = ST_STOP;
                        end
                        ST_STOP: begin
                            w_data_low_nxt = 1'b0;      // stop bit = 1 (released)
                            w_state_nxt    = ST_WAIT_ACK;
                        end
                        default: begin
`ifdef PS2_CMD_OUT_ACK_CHECK_EN
                            w_state_nxt = (ps2_data == PS2_ACK_LEVEL) ? ST_SENT : ST_ERROR;
`else
                            w_state_nxt = ST_SENT;
`endif
                        end
                    endcase
                end
            end

            ST_SENT, ST_ERROR: begin
                w_data_low_nxt = 1'b0;
                if (!send_command) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_data_low_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // Line drives and status decoded from the registered state
    assign ps2_clk_drive_low             = (r_state == ST_INHIBIT);
    assign ps2_data_drive_low            = r_data_low;
    assign busy                          = (r_state != ST_IDLE);
    assign command_was_sent              = (r_state == ST_SENT);
    assign error_communication_timed_out = (r_state == ST_ERROR);

endmodule

`default_nettype wire
